// File: rtl/reg_scoreboard.sv
// Register/condition-code scoreboard: counts in-flight writes per register and to the CCs,
// and derives the decode dependency stall from that counter state.
module reg_scoreboard #(
   parameter int NUM_REGS  = 8,
   parameter int ID_W      = 3,
   parameter int CNT_W     = 2,
   parameter int WB_BYPASS = 1,
   parameter int PERF_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              de_v,
   input  logic [ID_W-1:0]   de_sr1,
   input  logic [ID_W-1:0]   de_sr2,
   input  logic              de_sr1_needed,
   input  logic              de_sr2_needed,
   input  logic [ID_W-1:0]   de_dr,
   input  logic              de_ld_reg,
   input  logic              de_ld_cc,
   input  logic              de_br_op,
   input  logic              ld_agex,
   input  logic              sr_v,
   input  logic              sr_ld_reg,
   input  logic              sr_ld_cc,
   input  logic [ID_W-1:0]   sr_drid,
   output logic              dep_stall,
   output logic              agex_v,
   output logic              issue,
   output logic              full_stall,
   output logic              sb_busy,
   output logic              sb_err,
   output logic [PERF_W-1:0] stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [ID_W:0]    NREG    = (ID_W+1)'(NUM_REGS);
   localparam logic             BYP     = (WB_BYPASS != 0);

   logic [CNT_W-1:0]    reg_cnt [NUM_REGS];
   logic [CNT_W-1:0]    cc_cnt;
   logic [CNT_W-1:0]    sr1_cnt, sr2_cnt, dr_cnt;
   logic [NUM_REGS-1:0] reg_inc, reg_dec, reg_uflow;
   logic                ret_r, ret_cc;
   logic                sr1_pend, sr2_pend, cc_pend;
   logic                data_stall, sat_stall;
   logic                ret_oor, uflow;

   assign ret_r  = sr_v & sr_ld_reg;
   assign ret_cc = sr_v & sr_ld_cc;

   // Out-of-range ids never match a counter, so they read as zero (never pending, never saturated).
   always_comb begin
      sr1_cnt = '0;
      sr2_cnt = '0;
      dr_cnt  = '0;
      sb_busy = (cc_cnt != '0);
      for (int i = 0; i < NUM_REGS; i++) begin
         if (de_sr1 == ID_W'(i)) sr1_cnt = reg_cnt[i];
         if (de_sr2 == ID_W'(i)) sr2_cnt = reg_cnt[i];
         if (de_dr  == ID_W'(i)) dr_cnt  = reg_cnt[i];
         if (reg_cnt[i] != '0)   sb_busy = 1'b1;
      end
   end

   assign sr1_pend = (sr1_cnt != '0) &
                     ~(BYP & (sr1_cnt == CNT_ONE) & ret_r & (sr_drid == de_sr1));
   assign sr2_pend = (sr2_cnt != '0) &
                     ~(BYP & (sr2_cnt == CNT_ONE) & ret_r & (sr_drid == de_sr2));
   assign cc_pend  = (cc_cnt != '0) & ~(BYP & (cc_cnt == CNT_ONE) & ret_cc);

   assign data_stall = (de_sr1_needed & sr1_pend) | (de_sr2_needed & sr2_pend) |
                       (de_br_op & cc_pend);
   assign sat_stall  = (de_ld_reg & (dr_cnt == CNT_MAX) & ~(ret_r & (sr_drid == de_dr))) |
                       (de_ld_cc & (cc_cnt == CNT_MAX) & ~ret_cc);

   assign dep_stall  = de_v & (data_stall | sat_stall);
   assign full_stall = de_v & sat_stall & ~data_stall;
   assign agex_v     = de_v & ~dep_stall;
   assign issue      = agex_v & ld_agex;

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         reg_inc[i]   = issue & de_ld_reg & (de_dr == ID_W'(i));
         reg_dec[i]   = ret_r & (sr_drid == ID_W'(i));
         reg_uflow[i] = reg_dec[i] & (reg_cnt[i] == '0);
      end
   end

   assign ret_oor = ret_r & ({1'b0, sr_drid} >= NREG);
   assign uflow   = (|reg_uflow) | ret_oor | (ret_cc & (cc_cnt == '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) reg_cnt[i] <= '0;
         cc_cnt    <= '0;
         sb_err    <= 1'b0;
         stall_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_inc[i] & ~reg_dec[i])
               reg_cnt[i] <= reg_cnt[i] + CNT_ONE;
            else if (reg_dec[i] & ~reg_inc[i] & (reg_cnt[i] != '0))
               reg_cnt[i] <= reg_cnt[i] - CNT_ONE;
         end
         if ((issue & de_ld_cc) & ~ret_cc)
            cc_cnt <= cc_cnt + CNT_ONE;
         else if (ret_cc & ~(issue & de_ld_cc) & (cc_cnt != '0))
            cc_cnt <= cc_cnt - CNT_ONE;
         if (uflow) sb_err <= 1'b1;
         if (dep_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + PERF_W'(1);
      end
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: per-cycle comparison against an in-bench counter model,
// plus literal checks for the scenarios of interest (second instance: PERF_W=4, no bypass).
module tb_reg_scoreboard;

   localparam int NREGS = 8;
   localparam int CMAX  = 3;

   logic       clk, rst_n;
   logic       de_v, de_sr1_needed, de_sr2_needed, de_ld_reg, de_ld_cc, de_br_op, ld_agex;
   logic [2:0] de_sr1, de_sr2, de_dr, sr_drid;
   logic       sr_v, sr_ld_reg, sr_ld_cc;

   logic        dep_stall, agex_v, issue, full_stall, sb_busy, sb_err;
   logic [15:0] stall_cnt;
   logic        s_dep_stall, s_agex_v, s_issue, s_full_stall, s_sb_busy, s_sb_err;
   logic [3:0]  s_stall_cnt;

   int tests = 0;
   int fails = 0;

   reg_scoreboard #(.NUM_REGS(8), .ID_W(3), .CNT_W(2), .WB_BYPASS(1), .PERF_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .de_v(de_v), .de_sr1(de_sr1), .de_sr2(de_sr2),
      .de_sr1_needed(de_sr1_needed), .de_sr2_needed(de_sr2_needed), .de_dr(de_dr),
      .de_ld_reg(de_ld_reg), .de_ld_cc(de_ld_cc), .de_br_op(de_br_op), .ld_agex(ld_agex),
      .sr_v(sr_v), .sr_ld_reg(sr_ld_reg), .sr_ld_cc(sr_ld_cc), .sr_drid(sr_drid),
      .dep_stall(dep_stall), .agex_v(agex_v), .issue(issue), .full_stall(full_stall),
      .sb_busy(sb_busy), .sb_err(sb_err), .stall_cnt(stall_cnt));

   reg_scoreboard #(.NUM_REGS(8), .ID_W(3), .CNT_W(2), .WB_BYPASS(0), .PERF_W(4)) u_small (
      .clk(clk), .rst_n(rst_n), .de_v(de_v), .de_sr1(de_sr1), .de_sr2(de_sr2),
      .de_sr1_needed(de_sr1_needed), .de_sr2_needed(de_sr2_needed), .de_dr(de_dr),
      .de_ld_reg(de_ld_reg), .de_ld_cc(de_ld_cc), .de_br_op(de_br_op), .ld_agex(ld_agex),
      .sr_v(sr_v), .sr_ld_reg(sr_ld_reg), .sr_ld_cc(sr_ld_cc), .sr_drid(sr_drid),
      .dep_stall(s_dep_stall), .agex_v(s_agex_v), .issue(s_issue), .full_stall(s_full_stall),
      .sb_busy(s_sb_busy), .sb_err(s_sb_err), .stall_cnt(s_stall_cnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model of the default-parameter instance: plain integer counts per register and CC.
   int m_cnt [NREGS];
   int m_cc, m_stall;
   bit m_err;
   bit e_dep, e_full, e_agex, e_issue;

   function automatic bit pend_reg(input int id);
      if (id >= NREGS || m_cnt[id] == 0) return 1'b0;
      if (m_cnt[id] == 1 && sr_v && sr_ld_reg && int'(sr_drid) == id) return 1'b0;
      return 1'b1;
   endfunction

   function automatic void model_eval();
      bit data, sat, pcc;
      pcc  = (m_cc != 0) && !(m_cc == 1 && sr_v && sr_ld_cc);
      data = (de_sr1_needed && pend_reg(int'(de_sr1))) ||
             (de_sr2_needed && pend_reg(int'(de_sr2))) || (de_br_op && pcc);
      sat  = (de_ld_reg && m_cnt[de_dr] == CMAX && !(sr_v && sr_ld_reg && sr_drid == de_dr)) ||
             (de_ld_cc && m_cc == CMAX && !(sr_v && sr_ld_cc));
      e_dep   = de_v && (data || sat);
      e_full  = de_v && sat && !data;
      e_agex  = de_v && !e_dep;
      e_issue = e_agex && ld_agex;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) m_cnt[i] = 0;
         m_cc = 0; m_stall = 0; m_err = 1'b0;
      end else begin
         bit inc, dec, cinc, cdec;
         model_eval();
         inc  = e_issue && de_ld_reg;
         dec  = sr_v && sr_ld_reg;
         cinc = e_issue && de_ld_cc;
         cdec = sr_v && sr_ld_cc;
         if (dec && m_cnt[sr_drid] == 0) m_err = 1'b1;
         if (cdec && m_cc == 0) m_err = 1'b1;
         if (!(inc && dec && de_dr == sr_drid)) begin
            if (inc) m_cnt[de_dr] = m_cnt[de_dr] + 1;
            if (dec && m_cnt[sr_drid] > 0) m_cnt[sr_drid] = m_cnt[sr_drid] - 1;
         end
         if (!(cinc && cdec)) begin
            if (cinc) m_cc = m_cc + 1;
            if (cdec && m_cc > 0) m_cc = m_cc - 1;
         end
         if (e_dep && m_stall < 65535) m_stall = m_stall + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         bit busy;
         model_eval();
         busy = (m_cc != 0);
         for (int i = 0; i < NREGS; i++) if (m_cnt[i] != 0) busy = 1'b1;
         chk("cyc_dep_stall", 32'(dep_stall), 32'(e_dep));
         chk("cyc_full_stall", 32'(full_stall), 32'(e_full));
         chk("cyc_agex_v", 32'(agex_v), 32'(e_agex));
         chk("cyc_issue", 32'(issue), 32'(e_issue));
         chk("cyc_sb_busy", 32'(sb_busy), 32'(busy));
         chk("cyc_sb_err", 32'(sb_err), 32'(m_err));
         chk("cyc_stall_cnt", 32'(stall_cnt), 32'(m_stall));
      end
   end

   task automatic idle();
      de_v = 0; de_sr1 = 0; de_sr2 = 0; de_sr1_needed = 0; de_sr2_needed = 0;
      de_dr = 0; de_ld_reg = 0; de_ld_cc = 0; de_br_op = 0; ld_agex = 1;
      sr_v = 0; sr_ld_reg = 0; sr_ld_cc = 0; sr_drid = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] r);
      idle(); de_v = 1; de_dr = r; de_ld_reg = 1;
   endtask

   task automatic rd(input logic [2:0] r);
      idle(); de_v = 1; de_sr1 = r; de_sr1_needed = 1;
   endtask

   task automatic ret(input logic [2:0] r);
      sr_v = 1; sr_ld_reg = 1; sr_drid = r;
   endtask

   task automatic do_reset();
      idle(); rst_n = 0;
      step(); step();
      rst_n = 1;
   endtask

   initial begin
      idle();
      rst_n = 0;
      step(); step();
      rst_n = 1;

      // Immediately after reset
      de_v = 1; #2;
      chk("rst_busy", 32'(sb_busy), 0);
      chk("rst_stall_cnt", 32'(stall_cnt), 0);
      chk("rst_dep_stall", 32'(dep_stall), 0);
      chk("rst_issue", 32'(issue), 1);
      step();

      // RAW back-to-back on R3, resolved by a same-cycle retire
      wr(3); step();
      rd(3); #2;
      chk("raw_stall", 32'(dep_stall), 1);
      chk("raw_no_issue", 32'(issue), 0);
      step();
      rd(3); ret(3); #2;
      chk("raw_bypass_stall", 32'(dep_stall), 0);
      chk("raw_bypass_issue", 32'(issue), 1);
      step();
      rd(3); #2;
      chk("raw_after_busy", 32'(sb_busy), 0);
      chk("raw_after_stall", 32'(dep_stall), 0);
      step();

      // Mid-flight reset with two writes pending on R3
      wr(3); step(); wr(3); step();
      idle(); #2;
      chk("mid_busy_before", 32'(sb_busy), 1);
      rst_n = 0; #1;
      chk("mid_busy_in_reset", 32'(sb_busy), 0);
      #4 rst_n = 1;
      step();
      rd(3); #2;
      chk("mid_read_r3", 32'(dep_stall), 0);
      step();

      // Saturation of R5
      wr(5); step(); wr(5); step(); wr(5); step();
      wr(5); #2;
      chk("sat_stall", 32'(dep_stall), 1);
      chk("sat_full", 32'(full_stall), 1);
      step();
      wr(5); de_sr1 = 5; de_sr1_needed = 1; #2;
      chk("sat_data_full", 32'(full_stall), 0);
      chk("sat_data_dep", 32'(dep_stall), 1);
      step();
      wr(5); ret(5); #2;
      chk("sat_ret_stall", 32'(dep_stall), 0);
      chk("sat_ret_issue", 32'(issue), 1);
      step();
      wr(5); #2;
      chk("sat_still_max", 32'(full_stall), 1);
      step();
      idle(); ret(5); step(); idle(); ret(5); step(); idle(); ret(5); step();
      idle(); #2;
      chk("sat_drained", 32'(sb_busy), 0);

      // CC dependency
      idle(); de_v = 1; de_ld_cc = 1; step();
      idle(); de_v = 1; de_br_op = 1; #2;
      chk("cc_stall", 32'(dep_stall), 1);
      step();
      idle(); de_v = 1; de_br_op = 1; ld_agex = 0; sr_v = 1; sr_ld_cc = 1; #2;
      chk("cc_ret_stall", 32'(dep_stall), 0);
      chk("cc_ret_agex", 32'(agex_v), 1);
      chk("cc_ret_issue", 32'(issue), 0);
      step();
      idle(); de_v = 1; de_ld_cc = 1; ld_agex = 0; #2;
      chk("cc_noagex_issue", 32'(issue), 0);
      step();
      idle(); #2;
      chk("cc_noagex_busy", 32'(sb_busy), 0);

      // Underflow on R2
      idle(); ret(2); step();
      idle(); #2;
      chk("uflow_err", 32'(sb_err), 1);
      chk("uflow_busy", 32'(sb_busy), 0);
      step(); step();
      chk("uflow_sticky", 32'(sb_err), 1);

      // Stall counting; narrow non-bypass instance alongside
      do_reset();
      wr(1); step();
      rd(1);
      for (int i = 0; i < 20; i++) step();
      #2;
      chk("stall_cnt_20", 32'(stall_cnt), 20);
      chk("stall_cnt_sat15", 32'(s_stall_cnt), 15);
      rd(1); ret(1); #2;
      chk("byp1_stall", 32'(dep_stall), 0);
      chk("byp0_stall", 32'(s_dep_stall), 1);
      step();
      rd(1); #2;
      chk("byp0_next_stall", 32'(s_dep_stall), 0);
      chk("byp1_next_stall", 32'(dep_stall), 0);
      step();
      idle(); step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
